// File: rtl/vga_scan_ctrl.sv
// ============================================================================
// Module      : vga_scan_ctrl
// Description : 640x480@60 Hz raster timing generator and pixel sink.
//               Generates request coordinates for the renderer, takes the
//               renderer's pixel back PIX_LATENCY clocks later, and drives
//               sync/RGB pins with sync delayed to stay aligned with RGB.
//               Optional macro VGA_TEST_PATTERN_EN replaces pix_data with
//               eight 80-pixel vertical colour bars.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_scan_ctrl #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int PIX_LATENCY = 1
) (
  input  logic        vga_clk,
  input  logic        rst_sys_n,
  input  logic [11:0] pix_data,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        req_active,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_tick,
  output logic        line_tick
);

  // Counter limits and sync windows, sized to the counter widths
  localparam logic [9:0] c_h_last     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] c_v_last     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
  localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
  localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Pipeline word: {[bar index,] de, hs_n, vs_n}
`ifdef VGA_TEST_PATTERN_EN
  localparam int c_pw = 6;
`else
  localparam int c_pw = 3;
`endif
  localparam logic [c_pw-1:0] c_pipe_idle = c_pw'(3'b011);

  // The latency range is a build-time property, so reject it at elaboration
  if (PIX_LATENCY < 1 || PIX_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "vga_scan_ctrl: PIX_LATENCY must be in 1..4");
  end

  logic              r_started;
  logic [9:0]        r_h_req;
  logic [9:0]        r_v_req;
  logic [c_pw-1:0]   r_pipe [PIX_LATENCY];
  logic              r_hsync;
  logic              r_vsync;
  logic [11:0]       r_rgb;

  logic              w_de;
  logic              w_hs_n;
  logic              w_vs_n;
  logic [c_pw-1:0]   w_pipe_in;
  logic [c_pw-1:0]   w_last;
  logic [11:0]       w_pix_sel;

  // Counters hold at 0 for one clock after reset release so the first
  // post-reset clock presents (0,0) with line_tick asserted
  always_ff @(posedge vga_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_started <= 1'b0;
      r_h_req   <= '0;
      r_v_req   <= '0;
    end else if (!r_started) begin
      r_started <= 1'b1;
    end else if (r_h_req == c_h_last) begin
      r_h_req <= '0;
      r_v_req <= (r_v_req == c_v_last) ? '0 : r_v_req + 10'd1;
    end else begin
      r_h_req <= r_h_req + 10'd1;
    end
  end

  assign req_active = (r_h_req < c_h_vis) && (r_v_req < c_v_vis);
  assign x          = req_active ? r_h_req : '0;
  assign y          = req_active ? r_v_req[8:0] : '0;
  assign line_tick  = r_started && (r_h_req == '0);
  assign frame_tick = r_started && (r_h_req == '0) && (r_v_req == c_v_vis);

  // Display-side attributes of the pixel being requested right now
  assign w_de   = r_started && req_active;
  assign w_hs_n = !(r_started && (r_h_req >= c_hs_start) && (r_h_req <= c_hs_end));
  assign w_vs_n = !(r_started && (r_v_req >= c_vs_start) && (r_v_req <= c_vs_end));

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] w_bar_full;
  logic       w_unused;
  assign w_bar_full = r_h_req / 10'd80;
  assign w_pipe_in  = {w_bar_full[2:0], w_de, w_hs_n, w_vs_n};
  assign w_unused   = ^pix_data;
`else
  assign w_pipe_in  = {w_de, w_hs_n, w_vs_n};
`endif

  // Delay line matching the renderer's latency
  always_ff @(posedge vga_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int i = 0; i < PIX_LATENCY; i++) r_pipe[i] <= c_pipe_idle;
    end else begin
      r_pipe[0] <= w_pipe_in;
      for (int i = 1; i < PIX_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_last = r_pipe[PIX_LATENCY-1];

`ifdef VGA_TEST_PATTERN_EN
  // Colour bar lookup from the delayed bar index
  always_comb begin
    w_pix_sel = 12'h000;
    case (w_last[5:3])
      3'd0:    w_pix_sel = 12'hFFF;
      3'd1:    w_pix_sel = 12'hFF0;
      3'd2:    w_pix_sel = 12'h0FF;
      3'd3:    w_pix_sel = 12'h0F0;
      3'd4:    w_pix_sel = 12'hF0F;
      3'd5:    w_pix_sel = 12'hF00;
      3'd6:    w_pix_sel = 12'h00F;
      default: w_pix_sel = 12'h000;
    endcase
  end
`else
  assign w_pix_sel = pix_data;
`endif

  // Pin registers: sync shares the RGB register stage; blanking forces black
  always_ff @(posedge vga_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= 12'h000;
    end else begin
      r_hsync <= w_last[1];
      r_vsync <= w_last[0];
      r_rgb   <= w_last[2] ? w_pix_sel : 12'h000;
    end
  end

  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign vga_r = r_rgb[11:8];
  assign vga_g = r_rgb[7:4];
  assign vga_b = r_rgb[3:0];

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
// ============================================================================
// Module      : tb_vga_scan_ctrl
// Description : Self-checking bench for vga_scan_ctrl. Full horizontal
//               timing, shortened vertical timing so several frames fit.
//               Expected pin values come from the raster position computed
//               arithmetically from elapsed clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_scan_ctrl;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48, HT = HV + HF + HS + HB;
  localparam int VV = 6, VF = 2, VS = 2, VB = 2, VT = VV + VF + VS + VB;
  localparam int L  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pix_data = '0;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        req_active, hsync, vsync, frame_tick, line_tick;
  logic [3:0]  vga_r, vga_g, vga_b;

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIX_LATENCY(L)
  ) dut (
    .vga_clk(clk), .rst_sys_n(rst_n), .pix_data(pix_data),
    .x(x), .y(y), .req_active(req_active),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_tick(frame_tick), .line_tick(line_tick)
  );

  typedef struct packed { logic hs; logic vs; logic [11:0] rgb; } pin_t;
  typedef struct packed { logic [9:0] x; logic [8:0] y; logic act; logic lt; logic ft; } req_t;
  typedef struct packed { logic [9:0] x; logic [8:0] y; logic act; } ren_t;

  pin_t pin_q[$];
  req_t req_q[$];
  ren_t ren_q[$];

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel the display should show for raster position (h, v)
  function automatic logic [11:0] exp_pixel(input int h, input int v);
`ifdef VGA_TEST_PATTERN_EN
    case (h / 80)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
`else
    return {4'(h), 4'(v), 4'hA};
`endif
  endfunction

  function automatic logic [11:0] rand_pix();
    if ($urandom_range(0, 3) == 0) return 12'hFFF;
    return 12'($urandom);
  endfunction

  // Renderer model plus stimulus-side scoreboard push
  int t;
  bit d_prev = 1'b0;
  always @(negedge clk) begin
    int h, v;
    ren_t r;
    pin_t p;
    req_t q;
    if (run) begin
      if (!d_prev) begin
        t = 0;
        pin_q.delete(); req_q.delete(); ren_q.delete();
        for (int i = 0; i <= L; i++) pin_q.push_back({1'b1, 1'b1, 12'h000});
      end
      ren_q.push_back({x, y, req_active});
      if (ren_q.size() > L) begin
        r = ren_q.pop_front();
        pix_data = r.act ? {r.x[3:0], r.y[3:0], 4'hA} : rand_pix();
      end else begin
        pix_data = rand_pix();
      end
      h = t % HT;
      v = (t / HT) % VT;
      q.act = (h < HV) && (v < VV);
      q.x   = q.act ? 10'(h) : 10'd0;
      q.y   = q.act ? 9'(v) : 9'd0;
      q.lt  = (h == 0);
      q.ft  = (h == 0) && (v == VV);
      req_q.push_back(q);
      p.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
      p.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      p.rgb = q.act ? exp_pixel(h, v) : 12'h000;
      pin_q.push_back(p);
      t++;
    end
    d_prev = run;
  end

  // Monitor: pops expectations and measures sync/tick timing
  int mt, hs_low, vs_low, last_lt, last_ft;
  bit m_prev = 1'b0, hs_prev, vs_prev, have_lt, have_ft;
  always @(negedge clk) begin
    req_t q;
    pin_t p;
    #1;
    if (run) begin
      if (!m_prev) begin
        mt = 0; hs_low = 0; vs_low = 0;
        hs_prev = 1'b1; vs_prev = 1'b1; have_lt = 1'b0; have_ft = 1'b0;
      end
      if (req_q.size() > 0 && pin_q.size() > 0) begin
        q = req_q.pop_front();
        p = pin_q.pop_front();
        check("req_side", {x, y, req_active, line_tick, frame_tick}, q);
        check("pins", {hsync, vsync, vga_r, vga_g, vga_b}, p);
      end else begin
        check("queue_underflow", 32'd0, 32'd1);
      end
      if (line_tick) begin last_lt = mt; have_lt = 1'b1; end
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (hs_prev && !hsync && have_lt)
        check("hsync_fall_offset", mt - last_lt, HV + HF + L + 1);
      if (!hs_prev && hsync) begin check("hsync_width", hs_low, HS); hs_low = 0; end
      if (!vs_prev && vsync) begin check("vsync_width", vs_low, VS * HT); vs_low = 0; end
      if (frame_tick) begin
        if (have_ft) check("frame_period", mt - last_ft, HT * VT);
        last_ft = mt; have_ft = 1'b1;
      end
      hs_prev = hsync;
      vs_prev = vsync;
      mt++;
    end
    m_prev = run;
  end

  task automatic release_and_start();
    rst_n = 1'b1;
    @(posedge clk);
    run = 1'b1;
    @(negedge clk);
    #2;
    check("start_x", x, 0);
    check("start_y", y, 0);
    check("start_active", req_active, 1);
    check("start_line_tick", line_tick, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat ($urandom_range(3, 8)) @(negedge clk);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_line_tick", line_tick, 0);
    release_and_start();

    repeat (2 * HT * VT + $urandom_range(0, 2000)) @(negedge clk);

    // Reset mid-frame while both syncs are low
    #2;
    n = 0;
    while (!(hsync === 1'b0 && vsync === 1'b0) && n < 2 * HT * VT) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("wait_sync_low", (hsync === 1'b0 && vsync === 1'b0), 1);
    #1;
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_hsync", hsync, 1);
    check("midrst_vsync", vsync, 1);
    check("midrst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("midrst_x", x, 0);
    check("midrst_y", y, 0);
    check("midrst_ticks", {frame_tick, line_tick}, 0);
    repeat ($urandom_range(2, 5)) @(negedge clk);
    release_and_start();

    repeat ($urandom_range(2000, 4000)) @(negedge clk);
    @(posedge clk);
    run = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
